// File: rtl/axi_apb_pkg.sv
// Shared types and response codes for the AXI4-Lite to APB bridge.
package axi_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/apb_timeout_counter.sv
// Down-counter bounding the APB ACCESS phase; o_tc flags the last allowed cycle.
module apb_timeout_counter #(
  parameter int unsigned CYCLES = 4096
) (
  input  logic clock,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned W = $clog2(CYCLES + 1);

  logic [W-1:0] r_count;

  // Loaded during SETUP so the first ACCESS cycle sees CYCLES-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= W'(CYCLES - 1);
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc = i_en && (r_count == '0);

endmodule

// File: rtl/axi_lite_apb_bridge.sv
// AXI4-Lite slave to APB master bridge, one transaction in flight.
// Optional APB_TIMEOUT_EN bounds the ACCESS phase to TIMEOUT_CYCLES.
module axi_lite_apb_bridge
  import axi_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_awvalid,
  output logic              in_awready,
  input  logic [ADDR_W-1:0] in_awaddr,
  input  logic [2:0]        in_awprot,
  input  logic              in_wvalid,
  output logic              in_wready,
  input  logic [31:0]       in_wdata,
  input  logic [3:0]        in_wstrb,
  output logic              in_bvalid,
  input  logic              in_bready,
  output logic [1:0]        in_bresp,
  input  logic              in_arvalid,
  output logic              in_arready,
  input  logic [ADDR_W-1:0] in_araddr,
  input  logic [2:0]        in_arprot,
  output logic              in_rvalid,
  input  logic              in_rready,
  output logic [31:0]       in_rdata,
  output logic [1:0]        in_rresp,
  output logic [ADDR_W-1:0] out_paddr,
  output logic              out_psel,
  output logic              out_penable,
  output logic [2:0]        out_pprot,
  output logic              out_pwrite,
  output logic [31:0]       out_pwdata,
  output logic [3:0]        out_pstrb,
  input  logic              out_pready,
  input  logic [31:0]       out_prdata,
  input  logic              out_pslverr
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t            r_state, w_next;
  logic              r_last_wr, r_is_write;
  logic [ADDR_W-1:0] r_paddr;
  logic [2:0]        r_pprot;
  logic [31:0]       r_pwdata, r_rdata;
  logic [3:0]        r_pstrb;
  logic [1:0]        r_resp;
  logic              w_idle, w_wr_elig, w_rd_elig, w_grant_rd, w_grant_wr, w_timeout;

  // Readies are gated by reset so they drop the instant reset rises.
  assign w_idle     = (r_state == IDLE) && !reset;
  assign w_wr_elig  = in_awvalid && in_wvalid;
  assign w_rd_elig  = in_arvalid;
  assign w_grant_rd = w_idle && w_rd_elig && (!w_wr_elig || r_last_wr);
  assign w_grant_wr = w_idle && w_wr_elig && !w_grant_rd;

  assign in_arready = w_grant_rd;
  assign in_awready = w_grant_wr;
  assign in_wready  = w_grant_wr;

`ifdef APB_TIMEOUT_EN
  apb_timeout_counter #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .i_load (r_state == SETUP),
    .i_en   (r_state == ACCESS),
    .o_tc   (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    out_psel    = 1'b0;
    out_penable = 1'b0;
    in_bvalid   = 1'b0;
    in_rvalid   = 1'b0;
    case (r_state)
      IDLE:   if (w_grant_rd || w_grant_wr) w_next = SETUP;
      SETUP: begin
        out_psel = 1'b1;
        w_next   = ACCESS;
      end
      ACCESS: begin
        out_psel    = 1'b1;
        out_penable = 1'b1;
        if (out_pready || w_timeout) w_next = RESP;
      end
      RESP: begin
        in_bvalid = r_is_write;
        in_rvalid = !r_is_write;
        if (r_is_write ? in_bready : in_rready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Starts as "last was write" so the first contested grant goes to the read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_wr  <= 1'b1;
      r_is_write <= 1'b0;
      r_paddr    <= '0;
      r_pprot    <= '0;
      r_pwdata   <= '0;
      r_pstrb    <= '0;
      r_rdata    <= '0;
      r_resp     <= RESP_OKAY;
    end else begin
      if (w_grant_rd) begin
        r_last_wr  <= 1'b0;
        r_is_write <= 1'b0;
        r_paddr    <= in_araddr;
        r_pprot    <= in_arprot;
        r_pwdata   <= '0;
        r_pstrb    <= '0;
      end else if (w_grant_wr) begin
        r_last_wr  <= 1'b1;
        r_is_write <= 1'b1;
        r_paddr    <= in_awaddr;
        r_pprot    <= in_awprot;
        r_pwdata   <= in_wdata;
        r_pstrb    <= in_wstrb;
      end
      if (r_state == ACCESS) begin
        if (out_pready) begin
          r_rdata <= out_prdata;
          r_resp  <= out_pslverr ? RESP_SLVERR : RESP_OKAY;
        end else if (w_timeout) begin
          r_rdata <= '0;
          r_resp  <= RESP_SLVERR;
        end
      end
    end
  end

  assign out_paddr  = r_paddr;
  assign out_pprot  = r_pprot;
  assign out_pwrite = r_is_write;
  assign out_pwdata = r_pwdata;
  assign out_pstrb  = r_pstrb;
  assign in_rdata   = r_rdata;
  assign in_rresp   = r_resp;
  assign in_bresp   = r_resp;

endmodule

// File: doc/axi_lite_apb_bridge.md
AXI_LITE_APB_BRIDGE -- requirements
Module: axi_lite_apb_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 4096: APB ACCESS-phase cycles allowed before a forced error (used only with APB_TIMEOUT_EN).
REQ-002 Parameter ADDR_W, 32: width of AXI and APB addresses.
REQ-003 clock  in  1  single clock for all logic.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_awvalid in 1, in_awready out 1, in_awaddr in ADDR_W, in_awprot in 3: AXI4-Lite write-address channel.
REQ-006 in_wvalid in 1, in_wready out 1, in_wdata in 32, in_wstrb in 4: AXI4-Lite write-data channel.
REQ-007 in_bvalid out 1, in_bready in 1, in_bresp out 2: AXI4-Lite write-response channel.
REQ-008 in_arvalid in 1, in_arready out 1, in_araddr in ADDR_W, in_arprot in 3: AXI4-Lite read-address channel.
REQ-009 in_rvalid out 1, in_rready in 1, in_rdata out 32, in_rresp out 2: AXI4-Lite read-data channel.
REQ-010 out_paddr out ADDR_W, out_psel out 1, out_penable out 1, out_pprot out 3, out_pwrite out 1, out_pwdata out 32, out_pstrb out 4: APB master request to the SPI/flash APB slave.
REQ-011 out_pready in 1, out_prdata in 32, out_pslverr in 1: APB slave completion.

Function
REQ-012 The bridge SHALL use states IDLE, SETUP, ACCESS and RESP, with exactly one transaction outstanding.
REQ-013 In IDLE, a write SHALL be eligible only when in_awvalid and in_wvalid are both high; a read SHALL be eligible when in_arvalid is high.
REQ-014 If a read and a write are both eligible, the bridge SHALL grant the opposite type to the last granted one; after reset the read wins.
REQ-015 A grant SHALL pulse in_awready and in_wready together (write) or in_arready (read) for one cycle, latch address, prot, data and strb (pstrb=0 for reads), then go to SETUP.
REQ-016 SETUP SHALL last exactly one cycle with psel=1 and penable=0, then go to ACCESS.
REQ-017 ACCESS SHALL hold psel=1 and penable=1 with all request outputs stable until out_pready=1, then latch prdata and pslverr and go to RESP.
REQ-018 RESP SHALL hold in_bvalid (write) or in_rvalid (read) with resp=2'b10 if pslverr else 2'b00 until the matching ready, then return to IDLE.
REQ-019 psel and penable SHALL be low in IDLE and RESP, and all in_*ready SHALL be low outside IDLE.
REQ-020 Minimum latency SHALL be: grant at cycle 0, SETUP at 1, ACCESS at 2, valid response at 3 when pready arrives in the first ACCESS cycle.
REQ-021 Stalls of any length on pready, bready or rready SHALL neither drop nor duplicate a transaction.

Reset
REQ-022 Asserting reset SHALL immediately force IDLE, all valid, ready, psel and penable outputs to 0, and rdata, resp, paddr, pwdata, pstrb, pprot and pwrite to 0.
REQ-023 Reset during SETUP, ACCESS or RESP SHALL abandon the transaction with no response issued afterwards.

Configuration
REQ-024 With APB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles; reaching TIMEOUT_CYCLES without pready SHALL deassert psel and penable, respond 2'b10 with rdata=0, and enter RESP.
REQ-025 Without APB_TIMEOUT_EN, ACCESS SHALL wait indefinitely and no counter logic SHALL exist.

Structure
REQ-026 The package axi_apb_pkg SHALL hold the state enum, RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
REQ-027 The only sub-module SHALL be apb_timeout_counter, instantiated only under APB_TIMEOUT_EN.

Verification
REQ-028 Read 0x30000010 with pready after 40 cycles: psel for 41 cycles, then rvalid with the returned rdata and rresp=00.
REQ-029 Write 0x10001014 with data 0x1 and strb 0xF, pready immediate and pslverr=1: bvalid with bresp=10, and pwrite=1 held through ACCESS.
REQ-030 AR, AW and W all valid in the same cycle for two transactions: read is served first, then the write, with no lost beats.
REQ-031 rready held low for 10 cycles: rvalid and rdata stay stable and no new arready is issued.
REQ-032 Reset asserted mid-ACCESS: psel, penable and rvalid drop immediately, and the next read completes normally.
REQ-033 With APB_TIMEOUT_EN and TIMEOUT_CYCLES=16 and pready never asserted: rresp=10 and rdata=0 after 16 ACCESS cycles.
